// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath geometry and the weight-buffer FSM state type.
package tpu_pkg;

    localparam int TPU_DATA_W = 8;
    localparam int TPU_LANES  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/weight_bank.sv
// Weight storage: one synchronous write port and LANES combinational read ports.
module weight_bank
    import tpu_pkg::*;
#(
    parameter  int DATA_W = TPU_DATA_W,
    parameter  int DEPTH  = 64,
    parameter  int LANES  = TPU_LANES,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [LANES*ADDR_W-1:0]   rd_addr,
    output logic [LANES*DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset; writes issued while reset is asserted are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_rd
            assign rd_data[gi*DATA_W +: DATA_W] = mem[rd_addr[gi*ADDR_W +: ADDR_W]];
        end
    endgenerate

endmodule

// File: rtl/weight_buffer.sv
// Weight buffer: streams LANES-wide rows from the weight bank starting at ld_base.
module weight_buffer
    import tpu_pkg::*;
#(
    parameter  int DATA_W = TPU_DATA_W,
    parameter  int DEPTH  = 64,
    parameter  int LANES  = TPU_LANES,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int ROWS_W = ADDR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    ld_start,
    input  logic [ADDR_W-1:0]       ld_base,
    input  logic [ROWS_W-1:0]       ld_rows,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_row,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(LANES);

    wb_state_t state_reg, state_next;

    logic [LANES*DATA_W-1:0] out_row_reg;
    logic                    out_valid_reg;
    logic                    done_reg;
    logic [ROWS_W-1:0]       rows_left_reg;
    logic [ADDR_W-1:0]       next_addr_reg;

    logic                    accept_ld;
    logic                    ld_empty;
    logic                    row_fire;
    logic                    last_row;
    logic                    capture;
    logic [ADDR_W-1:0]       rd_base;
    logic [LANES*ADDR_W-1:0] rd_addr;
    logic [LANES*DATA_W-1:0] rd_data;

    assign accept_ld = (state_reg == IDLE) && ld_start;
    assign ld_empty  = (ld_rows == '0);
    assign row_fire  = (state_reg == STREAM) && out_valid_reg && out_ready;
    assign last_row  = (rows_left_reg == '0);
    assign capture   = (accept_ld && !ld_empty) || (row_fire && !last_row);

    // Row 0 is addressed straight from ld_base; later rows from the running pointer.
    assign rd_base = (state_reg == IDLE) ? ld_base : next_addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_addr
            assign rd_addr[gi*ADDR_W +: ADDR_W] = rd_base + ADDR_W'(gi);
        end
    endgenerate

    weight_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_ld && !ld_empty) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (row_fire && last_row) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg == STREAM);
        out_valid = out_valid_reg;
        out_row   = out_row_reg;
        done      = done_reg;
    end

    // The bank is read combinationally and sampled here, so a write landing on
    // the same edge is not seen by this capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_row_reg   <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            rows_left_reg <= '0;
            next_addr_reg <= '0;
        end else begin
            done_reg      <= (accept_ld && ld_empty) || (row_fire && last_row);
            out_valid_reg <= (state_next == STREAM);
            if (capture) begin
                out_row_reg <= rd_data;
            end
            if (accept_ld && !ld_empty) begin
                rows_left_reg <= ld_rows - ROWS_W'(1);
                next_addr_reg <= ld_base + ROW_STEP;
            end else if (row_fire && !last_row) begin
                rows_left_reg <= rows_left_reg - ROWS_W'(1);
                next_addr_reg <= next_addr_reg + ROW_STEP;
            end
        end
    end

endmodule

// File: tb/tb_weight_buffer.sv
// Directed bench for weight_buffer: streaming, wrap-around, back-pressure, read-first and reset.
module tb_weight_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int LANES  = 4;
    localparam int ADDR_W = 6;
    localparam int ROWS_W = 7;

    logic                    clk;
    logic                    reset;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    ld_start;
    logic [ADDR_W-1:0]       ld_base;
    logic [ROWS_W-1:0]       ld_rows;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_row;
    logic                    done;

    int checks = 0;
    int errors = 0;

    weight_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_rows   (ld_rows),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("check %-22s observed=%08h expected=%08h", tag, observed, expected);
    endtask

    task automatic status(input string tag, input logic b, input logic v, input logic d);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        ld_start  = 1'b0;
        ld_base   = '0;
        ld_rows   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        status("reset", 1'b0, 1'b0, 1'b0);
        check("reset.row", out_row, 32'h0);

        reset = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = DATA_W'(i);
            tick();
        end
        wr_en = 1'b0;

        // Two rows back to back from base 0
        out_ready = 1'b1;
        ld_start  = 1'b1;
        ld_base   = 6'd0;
        ld_rows   = 7'd2;
        tick();
        ld_start = 1'b0;
        status("ld2.r0", 1'b1, 1'b1, 1'b0);
        check("ld2.r0.row", out_row, 32'h03020100);
        tick();
        status("ld2.r1", 1'b1, 1'b1, 1'b0);
        check("ld2.r1.row", out_row, 32'h07060504);
        tick();
        status("ld2.end", 1'b0, 1'b0, 1'b1);
        tick();
        check("ld2.done_pulse", {31'd0, done}, 32'd0);

        // Wrap-around from base 62
        ld_start = 1'b1;
        ld_base  = 6'd62;
        ld_rows  = 7'd1;
        tick();
        ld_start = 1'b0;
        check("wrap.row", out_row, 32'h01003F3E);
        tick();
        status("wrap.end", 1'b0, 1'b0, 1'b1);

        // New load issued in the done cycle, then stalled with a stray ld_start
        ld_start  = 1'b1;
        ld_base   = 6'd8;
        ld_rows   = 7'd3;
        out_ready = 1'b0;
        tick();
        ld_start = 1'b0;
        status("bp.r0", 1'b1, 1'b1, 1'b0);
        check("bp.r0.row", out_row, 32'h0B0A0908);
        for (int i = 0; i < 4; i++) begin
            ld_start = (i == 1);
            ld_base  = 6'd40;
            ld_rows  = 7'd5;
            tick();
            check("bp.stall.row", out_row, 32'h0B0A0908);
            check("bp.stall.valid", {31'd0, out_valid}, 32'd1);
        end
        ld_start  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp.r1.row", out_row, 32'h0F0E0D0C);
        tick();
        check("bp.r2.row", out_row, 32'h13121110);
        status("bp.r2", 1'b1, 1'b1, 1'b0);
        tick();
        status("bp.end", 1'b0, 1'b0, 1'b1);
        tick();

        // Write to mem[4] on the edge that captures row 1
        ld_start = 1'b1;
        ld_base  = 6'd0;
        ld_rows  = 7'd2;
        tick();
        ld_start = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 6'd4;
        wr_data  = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("rf.old.row", out_row, 32'h07060504);
        tick();
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        tick();
        check("rf.new.row", out_row, 32'h070605AA);
        tick();
        tick();

        // Zero-row load
        ld_start = 1'b1;
        ld_rows  = 7'd0;
        tick();
        ld_start = 1'b0;
        status("zero", 1'b0, 1'b0, 1'b1);
        tick();
        status("zero.after", 1'b0, 1'b0, 1'b0);

        // Reset mid-stream, with a write attempted during reset
        out_ready = 1'b0;
        ld_start  = 1'b1;
        ld_base   = 6'd16;
        ld_rows   = 7'd4;
        tick();
        ld_start = 1'b0;
        check("rst.pre.valid", {31'd0, out_valid}, 32'd1);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 6'd10;
        wr_data = 8'hEE;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        status("rst.mid", 1'b0, 1'b0, 1'b0);
        check("rst.mid.row", out_row, 32'h0);
        tick();
        check("rst.no_done", {31'd0, done}, 32'd0);

        out_ready = 1'b1;
        ld_start  = 1'b1;
        ld_base   = 6'd8;
        ld_rows   = 7'd1;
        tick();
        ld_start = 1'b0;
        check("rst.mem_kept.row", out_row, 32'h0B0A0908);
        tick();
        status("rst.reload.end", 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
